serial_magnitude_comparator: RTL and testbench

- Bit-serial N-bit magnitude comparator; the multi-bit stage built on the 1-bit comparison cell.
- Captures two WIDTH-bit operands on a start handshake.
- Walks the operands MSB-first, one bit per clock.
- Reports smaller/equal/greater of A relative to B with a one-cycle done pulse, and holds the result until the next start.

---
 rtl/serial_magnitude_comparator.sv | 76 +++++++
 tb/tb_serial_magnitude_comparator.sv | 97 +++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial MSB-first unsigned compare of two latched operands
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  output logic                       busy,
  output logic                       done,
  output logic                       smaller,
  output logic                       equal,
  output logic                       greater,
  output logic [$clog2(WIDTH+1)-1:0] bits_examined
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [1:0] IDLE = 2'd0, COMPARE = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             gt, lt, first;
  // gt/lt hold the verdict privately so the outputs stay 0 until done
  always_comb first = (a_q[idx] ^ b_q[idx]) && !gt && !lt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      gt <= 1'b0;
      lt <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      smaller <= 1'b0;
      equal <= 1'b0;
      greater <= 1'b0;
      bits_examined <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q <= a_in;
          b_q <= b_in;
          idx <= IW'(WIDTH-1);
          gt <= 1'b0;
          lt <= 1'b0;
          bits_examined <= '0;
          smaller <= 1'b0;
          equal <= 1'b0;
          greater <= 1'b0;
          busy <= 1'b1;
          state <= COMPARE;
        end
      end else if (state == COMPARE) begin
        bits_examined <= bits_examined + CW'(1);
        if (first) begin
          gt <= a_q[idx];
          lt <= b_q[idx];
        end
        if ((EARLY_EXIT && first) || idx == '0) begin
          busy <= 1'b0;
          state <= DONE;
        end else idx <= idx - IW'(1);
      end else if (state == DONE) begin
        done <= 1'b1;
        greater <= gt;
        smaller <= lt;
        equal <= !gt && !lt;
        state <= IDLE;
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed checks of early-exit and full-scan instances
module tb_serial_magnitude_comparator;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic busy0, done0, sm0, eq0, gt0, busy1, done1, sm1, eq1, gt1;
  logic [3:0] be0, be1;
  int vectors = 0, miscompares = 0;

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .smaller(sm0), .equal(eq0), .greater(gt0), .bits_examined(be0));
  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .smaller(sm1), .equal(eq1), .greater(gt1), .bits_examined(be1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags are {smaller,equal,greater}; latency counts edges after the start edge
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input bit busy_start,
                     input int lat0_e, input int be0_e, input int lat1_e, input int be1_e, input logic [2:0] fl_e);
    int lat0 = 0, lat1 = 0;
    logic [2:0] fl0 = '0, fl1 = '0;
    logic [3:0] b0 = '0, b1 = '0;
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_flags0"}, {busy0, sm0, eq0, gt0}, 4'b1000);
    start = busy_start;
    if (busy_start) begin a_in = 8'h00; b_in = 8'hFF; end
    for (int n = 1; n <= 20 && (lat0 == 0 || lat1 == 0); n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done0 && lat0 == 0) begin lat0 = n; fl0 = {sm0, eq0, gt0}; b0 = be0; end
      if (done1 && lat1 == 0) begin lat1 = n; fl1 = {sm1, eq1, gt1}; b1 = be1; end
    end
    chk({tag, "_lat0"}, lat0, lat0_e);
    chk({tag, "_lat1"}, lat1, lat1_e);
    chk({tag, "_flags0"}, fl0, fl_e);
    chk({tag, "_flags1"}, fl1, fl_e);
    chk({tag, "_be0"}, b0, be0_e);
    chk({tag, "_be1"}, b1, be1_e);
  endtask

  initial begin
    bit saw_done;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out0", {busy0, done0, sm0, eq0, gt0, be0}, 9'h0);
    chk("reset_out1", {busy1, done1, sm1, eq1, gt1, be1}, 9'h0);
    start = 1'b0; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {busy0, done0, busy1, done1}, 4'h0);

    run("equal", 8'hA5, 8'hA5, 1'b0, 9, 8, 9, 8, 3'b010);
    repeat (5) @(posedge clk);
    #1;
    chk("held0", {done0, sm0, eq0, gt0, be0}, {4'b0010, 4'd8});
    chk("held1", {done1, sm1, eq1, gt1, be1}, {4'b0010, 4'd8});

    run("msb", 8'h80, 8'h7F, 1'b0, 2, 1, 9, 8, 3'b001);
    @(posedge clk); #1;
    run("lsb", 8'h12, 8'h13, 1'b0, 9, 8, 9, 8, 3'b100);
    run("b2b", 8'h01, 8'h02, 1'b0, 8, 7, 9, 8, 3'b100);
    @(posedge clk); #1;
    run("busy_start", 8'h40, 8'h10, 1'b1, 3, 2, 9, 8, 3'b001);
    @(posedge clk); #1;

    a_in = 8'h40; b_in = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midreset0", {busy0, done0, sm0, eq0, gt0, be0}, 9'h0);
    chk("midreset1", {busy1, done1, sm1, eq1, gt1, be1}, 9'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy0 || busy1) saw_done = 1'b1;
    end
    chk("no_done_after_reset", saw_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
